// File: rtl/mod_counter_pkg.sv
// Shared types and constants for the modulo counter family.
package mod_counter_pkg;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN
  } cnt_dir_t;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Opposing or absent requests cancel out.
  function automatic cnt_dir_t decode_dir(input logic up, input logic down);
    cnt_dir_t dir;
    dir = DIR_NONE;
    if (up && !down) begin
      dir = DIR_UP;
    end else if (down && !up) begin
      dir = DIR_DOWN;
    end
    return dir;
  endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// Request prescaler: one tick for every PRESCALE accepted requests.
module prescaler
  import mod_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clock,
  input  logic reset_l,
  input  logic clear_phase,
  input  logic req,
  output logic tick
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clock, reset_l, clear_phase};
      assign tick          = req;
    end else begin : g_phase
      localparam int unsigned PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] phase_q;
      logic [PW-1:0] phase_d;

      // Next phase: clear wins, otherwise advance and roll over on each request.
      always_comb begin
        phase_d = phase_q;
        if (clear_phase) begin
          phase_d = '0;
        end else if (req) begin
          phase_d = (phase_q == LAST) ? '0 : phase_q + 1'b1;
        end
      end

      // Phase register with synchronous active-low reset.
      always_ff @(posedge clock) begin
        if (!reset_l) begin
          phase_q <= '0;
        end else begin
          phase_q <= phase_d;
        end
      end

      assign tick = req && (phase_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with inclusive limit, load, wrap/saturate and prescaler.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SATURATE = MODE_WRAP,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset_l,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] out,
  output logic             at_top,
  output logic             at_zero,
  output logic             ovf
);

  cnt_dir_t         dir;
  logic             req;
  logic             tick;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic             ovf_q;
  logic             ovf_d;

  assign dir = decode_dir(up, down);
  assign req = (dir != DIR_NONE);

  prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clock      (clock),
    .reset_l    (reset_l),
    .clear_phase(clear || load),
    .req        (req),
    .tick       (tick)
  );

  assign at_top  = (out_q >= limit);
  assign at_zero = (out_q == '0);

  // Next count and boundary flag: clear > load > completed step.
  always_comb begin
    out_d = out_q;
    ovf_d = 1'b0;
    if (clear) begin
      out_d = '0;
    end else if (load) begin
      out_d = load_val;
    end else if (tick) begin
      case (dir)
        DIR_UP: begin
          if (at_top) begin
            ovf_d = 1'b1;
            if (SATURATE == MODE_WRAP) begin
              out_d = '0;
            end
          end else begin
            out_d = out_q + 1'b1;
          end
        end
        DIR_DOWN: begin
          if (at_zero) begin
            ovf_d = 1'b1;
            if (SATURATE == MODE_WRAP) begin
              out_d = limit;
            end
          end else begin
            out_d = out_q - 1'b1;
          end
        end
        default: begin
          out_d = out_q;
        end
      endcase
    end
  end

  // Count and overflow registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_l) begin
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign out = out_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench: three counter configurations share one stimulus stream.
module tb_mod_counter;

  localparam int unsigned NDUT = 3;
  // dut 0: wrap, PRESCALE 1; dut 1: saturate, PRESCALE 1; dut 2: wrap, PRESCALE 3
  localparam int unsigned CFG_SAT [NDUT] = '{0, 1, 0};
  localparam int unsigned CFG_PRE [NDUT] = '{1, 1, 3};

  typedef struct {
    logic [7:0] out;
    logic       ovf;
  } exp_t;

  logic       clock;
  logic       reset_l;
  logic       clear;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] limit;
  logic       up;
  logic       down;

  logic [7:0] dout  [NDUT];
  logic       dtop  [NDUT];
  logic       dzero [NDUT];
  logic       dovf  [NDUT];

  logic [7:0]  m_out [NDUT];
  logic        m_ovf [NDUT];
  int unsigned m_ph  [NDUT];

  exp_t sb[$];
  int   n_checks;
  int   n_errors;

  mod_counter #(.WIDTH(8), .SATURATE(0), .PRESCALE(1)) u_wrap (
    .clock(clock), .reset_l(reset_l), .clear(clear), .load(load), .load_val(load_val),
    .limit(limit), .up(up), .down(down), .out(dout[0]), .at_top(dtop[0]),
    .at_zero(dzero[0]), .ovf(dovf[0])
  );

  mod_counter #(.WIDTH(8), .SATURATE(1), .PRESCALE(1)) u_sat (
    .clock(clock), .reset_l(reset_l), .clear(clear), .load(load), .load_val(load_val),
    .limit(limit), .up(up), .down(down), .out(dout[1]), .at_top(dtop[1]),
    .at_zero(dzero[1]), .ovf(dovf[1])
  );

  mod_counter #(.WIDTH(8), .SATURATE(0), .PRESCALE(3)) u_pre (
    .clock(clock), .reset_l(reset_l), .clear(clear), .load(load), .load_val(load_val),
    .limit(limit), .up(up), .down(down), .out(dout[2]), .at_top(dtop[2]),
    .at_zero(dzero[2]), .ovf(dovf[2])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference behaviour of one counter for one clock edge.
  task automatic model_edge(input int unsigned i);
    logic req_up;
    logic req_dn;
    req_up = up && !down;
    req_dn = down && !up;
    if (!reset_l) begin
      m_out[i] = 8'd0; m_ph[i] = 0; m_ovf[i] = 1'b0;
    end else if (clear) begin
      m_out[i] = 8'd0; m_ph[i] = 0; m_ovf[i] = 1'b0;
    end else if (load) begin
      m_out[i] = load_val; m_ph[i] = 0; m_ovf[i] = 1'b0;
    end else if (req_up || req_dn) begin
      m_ovf[i] = 1'b0;
      if (m_ph[i] != CFG_PRE[i] - 1) begin
        m_ph[i] = m_ph[i] + 1;
      end else begin
        m_ph[i] = 0;
        if (req_up) begin
          if (m_out[i] >= limit) begin
            m_ovf[i] = 1'b1;
            if (CFG_SAT[i] == 0) m_out[i] = 8'd0;
          end else begin
            m_out[i] = m_out[i] + 8'd1;
          end
        end else begin
          if (m_out[i] == 8'd0) begin
            m_ovf[i] = 1'b1;
            if (CFG_SAT[i] == 0) m_out[i] = limit;
          end else begin
            m_out[i] = m_out[i] - 8'd1;
          end
        end
      end
    end else begin
      m_ovf[i] = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, check pre-edge flags, queue and then compare post-edge state.
  task automatic cycle(input logic rl, input logic clr, input logic ld, input logic [7:0] lv,
                       input logic u, input logic d);
    exp_t e;
    @(negedge clock);
    reset_l = rl; clear = clr; load = ld; load_val = lv; up = u; down = d;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("hold_out%0d", i), {24'd0, dout[i]}, {24'd0, m_out[i]});
      chk($sformatf("at_top%0d", i), {31'd0, dtop[i]}, {31'd0, (m_out[i] >= limit)});
      chk($sformatf("at_zero%0d", i), {31'd0, dzero[i]}, {31'd0, (m_out[i] == 8'd0)});
      model_edge(i);
      e.out = m_out[i];
      e.ovf = m_ovf[i];
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      e = sb.pop_front();
      chk($sformatf("out%0d", i), {24'd0, dout[i]}, {24'd0, e.out});
      chk($sformatf("ovf%0d", i), {31'd0, dovf[i]}, {31'd0, e.ovf});
    end
  endtask

  task automatic step_up(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
  endtask

  task automatic step_dn(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
  endtask

  task automatic do_clear();
    cycle(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_l = 1'b0; clear = 1'b0; load = 1'b0; load_val = 8'd0;
    limit = 8'd5; up = 1'b0; down = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      m_out[i] = 8'd0; m_ovf[i] = 1'b0; m_ph[i] = 0;
    end
    repeat (2) @(posedge clock);
    #1;

    // 1: reset dominates an up request, then count 1..5,0,1
    cycle(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    step_up(7);
    chk("t1_final", {24'd0, dout[0]}, 32'd1);

    // 2: saturate at 3 going up, then at 0 going down
    do_clear();
    limit = 8'd3;
    step_up(6);
    chk("t2_top", {24'd0, dout[1]}, 32'd3);
    step_dn(5);
    chk("t2_bot", {24'd0, dout[1]}, 32'd0);

    // 3: down from 0 wraps to the limit
    do_clear();
    limit = 8'd9;
    step_dn(2);
    chk("t3_final", {24'd0, dout[0]}, 32'd8);

    // 4: prescaler by 3 with a clear part way through
    do_clear();
    limit = 8'd255;
    step_up(3);
    chk("t4_first", {24'd0, dout[2]}, 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
    step_up(2);
    chk("t4_mid", {24'd0, dout[2]}, 32'd0);
    step_up(1);
    chk("t4_land", {24'd0, dout[2]}, 32'd1);

    // 5: priority and cancelling requests
    cycle(1'b1, 1'b1, 1'b1, 8'd77, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 8'd200, 1'b1, 1'b0);
    chk("t5_load", {24'd0, dout[0]}, 32'd200);
    step_up(1);
    cycle(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    step_up(2);

    // 6: load above limit, lowered limit, mid-count reset, limit of zero
    limit = 8'd10;
    cycle(1'b1, 1'b0, 1'b1, 8'd20, 1'b0, 1'b0);
    step_up(1);
    chk("t6_over", {24'd0, dout[0]}, 32'd0);
    chk("t6_ovf", {31'd0, dovf[0]}, 32'd1);
    cycle(1'b1, 1'b0, 1'b1, 8'd7, 1'b0, 1'b0);
    limit = 8'd4;
    step_up(1);
    chk("t6_lower", {24'd0, dout[0]}, 32'd0);
    limit = 8'd255;
    cycle(1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0);
    step_up(2);
    cycle(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    limit = 8'd0;
    do_clear();
    step_up(3);
    step_dn(3);

    // Random traffic including narrow and zero limits
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(7) == 0) limit = 8'($urandom_range(4));
      else if ($urandom_range(9) == 0) limit = 8'($urandom);
      cycle(($urandom_range(40) != 0), ($urandom_range(25) == 0), ($urandom_range(15) == 0),
            8'($urandom_range(12)), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
Parametrised successor to the basic up-counter: an up/down modulo counter with a programmable inclusive limit, load, selectable wrap or saturate mode, and an optional input prescaler. It serves as the general timing and indexing primitive for video timing, tile and sprite walkers, and audio sample dividers. The block runs on a single clock with synchronous reset.

Parameters:
WIDTH, 8, bit width of the count, limit and load value (>= 1)
SATURATE, 0, 0 = wrap at the boundaries, 1 = hold at the boundaries
PRESCALE, 1, number of accepted step requests per actual count step (>= 1)

Ports:
clock  input  1  system clock; all state updates on posedge
reset_l  input  1  synchronous active-low reset, sampled on posedge clock
clear  input  1  force count and prescaler phase to 0
load  input  1  force count to load_val and prescaler phase to 0
load_val  input  WIDTH  value taken on load
limit  input  WIDTH  inclusive top of the count range; may change at any time
up  input  1  step request, increment direction
down  input  1  step request, decrement direction
out  output  WIDTH  current count (registered)
at_top  output  1  combinational: out >= limit
at_zero  output  1  combinational: out == 0
ovf  output  1  registered one-cycle pulse: a boundary event happened on the previous step

Behaviour:
- Reset (reset_l low at posedge): out = 0, prescaler phase = 0, ovf = 0. Reset dominates every other input.
- Priority each cycle: reset > clear > load > step. clear and load zero the phase and drive ovf low that cycle.
- Step request: req = up XOR down. If up and down are both high, or both low, there is no request and no phase change.
- Prescaler: phase counts from 0 to PRESCALE-1 on each req.
  - A req with phase == PRESCALE-1 produces a step and phase returns to 0.
  - Otherwise phase increments and out holds.
  - The direction of a step comes from the req that completes it.
  - With PRESCALE = 1, every req is a step and there is no phase register.
- Up step:
  - If out >= limit: wrap mode sets out = 0; saturate mode holds out. ovf = 1 next cycle in both modes.
  - Otherwise out = out + 1.
- Down step:
  - If out == 0: wrap mode sets out = limit; saturate mode holds at 0. ovf = 1 next cycle.
  - Otherwise out = out - 1.
- ovf is high for exactly one cycle per boundary step. It is low on non-boundary steps, idle cycles, clear, load and reset.
- Latency: out and ovf both update on the posedge after the completing req.
- load_val > limit: the value is loaded as-is. The next up step is treated as a boundary (>= compare). A down step decrements normally.
- limit changed below the current out: at_top asserts immediately. Behaviour then follows the up and down step rules above.
- limit = 0: an up step is always a boundary. A down step at 0 wraps to 0 in wrap mode. ovf pulses in both cases.
- Arithmetic is unsigned, modulo 2^WIDTH internally, with no overflow beyond the limit rules.
- Reset asserted mid-prescale discards the phase.

Decomposition:
- Package mod_counter_pkg holds:
  - typedef cnt_dir_t {DIR_NONE, DIR_UP, DIR_DOWN}, decoded from up/down;
  - localparam MODE_WRAP = 0, MODE_SAT = 1.
- Sub-module prescaler (parameter PRESCALE): inputs clock, reset_l, clear_phase, req; output tick.
  - tick is combinational: req && phase == PRESCALE-1.
  - Generate bypass when PRESCALE == 1.
- The top level holds the next-count mux, boundary compares and the ovf register.

Test Plan:
1. Reset and basic count, WIDTH=8, limit=5, wrap, PRESCALE=1. Hold reset_l low 2 cycles, then up for 7 cycles.
   Required: out stays 0 through reset, then reads 1,2,3,4,5,0,1. ovf is high only in the cycle after out reaches 0.
2. Saturate, limit=3. Up for 6 cycles, then down for 5 cycles.
   Required: out 1,2,3,3,3,3, then 2,1,0,0,0. ovf pulses on each held cycle (3 at the top, 2 at the bottom).
3. Down wrap, limit=9, from 0. Down for 2 cycles.
   Required: out 9 with ovf=1 next cycle, then 8 with ovf=0.
4. Prescaler, PRESCALE=3, limit=255. Up for 7 cycles, clear on cycle 4, then 3 more up cycles.
   Required: out 1 after the 3rd up. Clear zeroes out and phase. The next step lands exactly 3 reqs after the clear.
5. Priority and simultaneity.
   - clear+load+up together: out=0.
   - load(200)+up: out=200, ovf=0.
   - up+down together: out and phase unchanged.
6. Edge cases, wrap mode.
   - limit=10, load 20, then up: out=0, ovf=1.
   - At out=7, lower limit to 4: at_top asserts combinationally; the next up gives out=0.
   - Synchronous reset mid-count: out=0 at that posedge, not before.
